mips_fetch_buffer: RTL



---
 rtl/mips_fetch_buffer.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/mips_fetch_buffer.sv
// mips_fetch_buffer
//   Instruction-fetch stage behind a free-running PC counter. Each cycle the
//   incoming pc is issued to a synchronous instruction memory (one-cycle read
//   latency). The returned word is paired with its pc and queued in a small
//   first-word-fall-through FIFO that feeds decode through a valid/ready
//   handshake. The PC cannot stall, so fetches that cannot be queued are
//   dropped and counted.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   pc                  current PC from the PC counter
//   flush               discard queued and in-flight fetches
//   imem_en, imem_addr  memory read strobe / address (addr = pc)
//   imem_rdata          read data, valid the cycle after imem_en
//   out_valid/out_ready head-entry handshake towards decode
//   out_pc, out_instr   head entry
//   out_opcode..out_imm pure bit slices of out_instr
//   overflow            sticky: at least one fetch dropped since reset
//   drop_cnt            saturating count of dropped fetches
module mips_fetch_buffer #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              imem_en,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_pc,
  output logic [DATA_W-1:0] out_instr,
  output logic [5:0]        out_opcode,
  output logic [4:0]        out_rs,
  output logic [4:0]        out_rt,
  output logic [4:0]        out_rd,
  output logic [15:0]       out_imm,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic              req_valid_q, req_valid_d;
  logic [ADDR_W-1:0] req_pc_q, req_pc_d;
  logic              overflow_q, overflow_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic [ADDR_W-1:0] pc_mem_q    [DEPTH];
  logic [DATA_W-1:0] instr_mem_q [DEPTH];

  logic              pop;
  logic              push;
  logic              credit_ok;
  logic              drop;
  logic [CNT_W:0]    used_w;
  logic [CNT_W:0]    limit_w;

  assign out_valid = (count_q != '0);
  assign pop       = out_valid && out_ready;
  assign push      = req_valid_q && !flush;

  // Credit check written as used < DEPTH + pop so nothing can underflow:
  // an in-flight read already owns a slot, hence a push never sees a full FIFO.
  assign used_w    = {1'b0, count_q} + {{CNT_W{1'b0}}, req_valid_q};
  assign limit_w   = (CNT_W+1)'(DEPTH) + {{CNT_W{1'b0}}, pop};
  assign credit_ok = (used_w < limit_w);

  assign imem_en   = !rst && !flush && credit_ok;
  assign imem_addr = pc;
  // Flush cycles are deliberate discards, not drops.
  assign drop      = !flush && !credit_ok;

  assign out_pc     = pc_mem_q[rd_ptr_q];
  assign out_instr  = instr_mem_q[rd_ptr_q];
  assign out_opcode = out_instr[31:26];
  assign out_rs     = out_instr[25:21];
  assign out_rt     = out_instr[20:16];
  assign out_rd     = out_instr[15:11];
  assign out_imm    = out_instr[15:0];

  assign overflow = overflow_q;
  assign drop_cnt = drop_cnt_q;

  always_comb begin
    count_d     = count_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    req_valid_d = req_valid_q;
    req_pc_d    = req_pc_q;
    overflow_d  = overflow_q;
    drop_cnt_d  = drop_cnt_q;

    if (flush) begin
      // In-flight data and any same-cycle pop are discarded.
      count_d     = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      req_valid_d = 1'b0;
    end else begin
      count_d     = count_q + CNT_W'(push) - CNT_W'(pop);
      wr_ptr_d    = wr_ptr_q + PTR_W'(push);
      rd_ptr_d    = rd_ptr_q + PTR_W'(pop);
      req_valid_d = imem_en;
      if (imem_en) begin
        req_pc_d = pc;
      end
    end

    if (drop) begin
      overflow_d = 1'b1;
      if (drop_cnt_q != '1) begin
        drop_cnt_d = drop_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q     <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      req_valid_q <= 1'b0;
      req_pc_q    <= '0;
      overflow_q  <= 1'b0;
      drop_cnt_q  <= '0;
    end else begin
      count_q     <= count_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      req_valid_q <= req_valid_d;
      req_pc_q    <= req_pc_d;
      overflow_q  <= overflow_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  // Entry storage needs no reset: it is only observed while out_valid is high.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_mem_q[wr_ptr_q]    <= req_pc_q;
      instr_mem_q[wr_ptr_q] <= imem_rdata;
    end
  end

endmodule
